addsub_nibble_seq: RTL and testbench

Sequencing controller that performs multi-nibble add/subtract on one shared 4-bit ripple slice. It issues one nibble per cycle, least-significant first, and carries between nibbles through a registered carry. It sits between a requester that wants wide (default 16-bit) add/sub results and the team's 4-bit full-adder datapath, trading latency for area. The requester sees a start/busy/done handshake with held results.

---
 rtl/addsub_nibble_seq.sv | 135 +++++++++++++
 tb/tb_addsub_nibble_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsub_nibble_seq
// Purpose  : Wide add/subtract sequenced over one shared 4-bit slice, one
//            nibble per cycle LSB first, with start/busy/done handshake.
//            Define ADDSUB_SEQ_OVF_EN to compute signed overflow on `ovf`.
// Revision : 1.0  initial release
// ============================================================================
module addsub_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   mode,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);
    localparam int c_W     = 4 * NIBBLES;
    localparam int c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIBBLES - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_W-1:0]     r_a;
    logic [c_W-1:0]     r_b;
    logic               r_mode;
    logic               r_c;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_W-1:0]     r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_y;
    logic [4:0]         w_full;

    // A new request may enter from IDLE or straight out of DONE.
    assign w_accept = start && (r_state != c_ST_RUN);
    assign w_last   = (r_idx == c_LAST_IDX);
    assign w_a_nib  = r_a[{r_idx, 2'b00} +: 4];
    assign w_y      = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_mode}};
    assign w_full   = {1'b0, w_a_nib} + {1'b0, w_y} + {4'b0000, r_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: w_state_nxt = w_accept ? c_ST_RUN : c_ST_IDLE;
            c_ST_RUN:  w_state_nxt = w_last ? c_ST_DONE : c_ST_RUN;
            c_ST_DONE: w_state_nxt = w_accept ? c_ST_RUN : c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_ST_RUN:  busy = 1'b1;
            c_ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_mode <= 1'b0;
            r_c    <= 1'b0;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_c    <= mode;   // +1 completes the two's complement of B
            r_idx  <= '0;
        end else if (r_state == c_ST_RUN) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_full[3:0];
            r_c   <= w_full[4];
            r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_full[4];
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef ADDSUB_SEQ_OVF_EN
    logic [3:0] w_lo;
    logic       r_ovf;

    // Bit-3 carry-in tap: low three bits summed on their own.
    assign w_lo = {1'b0, w_a_nib[2:0]} + {1'b0, w_y[2:0]} + {3'b000, r_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (!w_accept && (r_state == c_ST_RUN) && w_last) begin
            r_ovf <= w_lo[3] ^ w_full[4];
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_nibble_seq.sv
`default_nettype none
// Bench for addsub_nibble_seq: arithmetic reference model plus directed vectors.
module tb_addsub_nibble_seq;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         busy;
    logic         done;
    logic         cout;
    logic         ovf;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    addsub_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang, required finish");
        $fatal(1);
    end

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain W-bit add/sub with signed overflow rules.
    function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                                   output logic [W-1:0] s, output logic c, output logic o);
        logic [W:0] t;
        if (!m) begin
            t = {1'b0, x} + {1'b0, y};
            s = t[W-1:0];
            c = t[W];
            o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        end else begin
            s = x - y;
            c = (x >= y);
            o = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        end
`ifndef ADDSUB_SEQ_OVF_EN
        o = 1'b0;
`endif
    endfunction

    // Transaction-level model: an accepted request finishes NIB edges later.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    int           m_left = 0;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;
    logic         was_busy;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else begin
            was_busy = m_busy;
            m_done   = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
                end
            end
            if (!was_busy && start) begin
                ref_op(a, b, mode, p_sum, p_cout, p_ovf);
                m_busy = 1'b1;
                m_left = NIB;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk1("cmp_busy", busy, m_busy);
            chk1("cmp_done", done, m_done);
            if (!m_busy) begin
                chkw("cmp_sum", sum, m_sum);
                chk1("cmp_cout", cout, m_cout);
                chk1("cmp_ovf", ovf, m_ovf);
            end
        end
    end

    task automatic wait_done(output int cyc, output int nb);
        cyc = 0;
        nb  = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: done not seen after %0d cycles, required within %0d", cyc, NIB);
        end
    endtask

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm,
                      input logic [W-1:0] es, input logic ec, input logic eo);
        logic [W-1:0] rs;
        logic         rc, ro, eo_eff;
        int           cyc, nb;
        eo_eff = eo;
`ifndef ADDSUB_SEQ_OVF_EN
        eo_eff = 1'b0;
`endif
        ref_op(ta, tb_v, tm, rs, rc, ro);
        chkw("model_sum", rs, es);
        chk1("model_cout", rc, ec);
        chk1("model_ovf", ro, eo_eff);
        @(negedge clk);
        a = ta; b = tb_v; mode = tm; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; mode = ~tm;
        wait_done(cyc, nb);
        chkw("latency", W'(cyc), W'(NIB));
        chkw("busy_cycles", W'(nb), W'(NIB));
        chkw("sum", sum, es);
        chk1("cout", cout, ec);
        chk1("ovf", ovf, eo_eff);
    endtask

    initial begin
        int cyc, nb;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkw("rst_sum", sum, 16'h0000);
        chk1("rst_cout", cout, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

        // start with new operands mid-run must be ignored
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, nb);
        chkw("ignore_sum", sum, 16'h3333);
        chk1("ignore_cout", cout, 1'b0);
        repeat (3) @(negedge clk);
        chkw("hold_sum", sum, 16'h3333);
        chk1("hold_done", done, 1'b0);

        // start held through DONE: second operation follows with no idle cycle
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; mode = 1'b1;
        wait_done(cyc, nb);
        chkw("b2b_first_sum", sum, 16'h0100);
        chk1("b2b_first_cout", cout, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk1("b2b_busy_again", busy, 1'b1);
        wait_done(cyc, nb);
        chkw("b2b_latency", W'(cyc), W'(NIB));
        chkw("b2b_second_sum", sum, 16'hFF00);
        chk1("b2b_second_cout", cout, 1'b0);
        chk1("b2b_second_ovf", ovf, 1'b0);

        // reset during the second RUN cycle aborts without a done pulse
        @(negedge clk);
        a = 16'h5555; b = 16'h1111; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chkw("abort_sum", sum, 16'h0000);
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            chk1("abort_no_done", done, 1'b0);
        end
        op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
